// File: rtl/pipe_reg_slice_pkg.sv
// pipe_pkg: shared constants and types for the pipe_reg_slice family.
//   MODE_SKID / MODE_HALF : slice implementation selectors
//   slice_state_t         : occupancy state of a skid-mode slice
package pipe_pkg;
    localparam int MODE_SKID = 0;  // 2 entries per slice, 1 beat/cycle
    localparam int MODE_HALF = 1;  // 1 entry per slice, 1 beat/2 cycles

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } slice_state_t;
endpackage

// File: rtl/pipe_reg_slice_stage.sv
// pipe_reg_slice_stage: one valid/ready register slice.
//   MODE_SKID: main + skid register, full throughput, ready from state flop.
//   MODE_HALF: single register, ready = !valid, one beat every two cycles.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   up_data/up_valid/up_ready       upstream handshake (up_ready from flops)
//   down_data/down_valid/down_ready downstream handshake (data/valid are flops)
module pipe_reg_slice_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MODE   = MODE_SKID
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [DATA_W-1:0] down_data,
    output logic              down_valid,
    input  logic              down_ready
);

    generate
        if (MODE == MODE_SKID) begin : g_skid
            slice_state_t      state_q, state_d;
            logic [DATA_W-1:0] main_q, skid_q;
            logic              acc, tak;

            assign acc = up_valid && (state_q != ST_FULL);
            assign tak = down_ready && (state_q != ST_EMPTY);

            always_comb begin
                state_d = state_q;
                case (state_q)
                    ST_EMPTY: if (acc) state_d = ST_BUSY;
                    ST_BUSY: begin
                        if (acc && !tak)      state_d = ST_FULL;
                        else if (!acc && tak) state_d = ST_EMPTY;
                    end
                    ST_FULL:  if (tak) state_d = ST_BUSY;
                    default:  state_d = ST_EMPTY;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) state_q <= ST_EMPTY;
                else        state_q <= state_d;
            end

            // main takes the input when it is free or being drained in the
            // same cycle; when full, the drained main is refilled from skid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    if (acc && (state_q == ST_EMPTY || tak))
                        main_q <= up_data;
                    else if (state_q == ST_FULL && tak)
                        main_q <= skid_q;
                    if (state_q == ST_BUSY && acc && !tak)
                        skid_q <= up_data;
                end
            end

            assign up_ready   = (state_q != ST_FULL);
            assign down_valid = (state_q != ST_EMPTY);
            assign down_data  = main_q;
        end else begin : g_half
            logic              valid_q;
            logic [DATA_W-1:0] data_q;
            logic              acc, tak;

            // ready = !valid, so accept and take can never coincide.
            assign acc = up_valid && !valid_q;
            assign tak = down_ready && valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    if (tak)      valid_q <= 1'b0;
                    else if (acc) valid_q <= 1'b1;
                    if (acc) data_q <= up_data;
                end
            end

            assign up_ready   = !valid_q;
            assign down_valid = valid_q;
            assign down_data  = data_q;
        end
    endgenerate

endmodule

// File: rtl/pipe_reg_slice.sv
// pipe_reg_slice: STAGES cascaded valid/ready register slices.
// Every handshake signal is cut by a flop; forward latency is STAGES cycles.
// Optional feature macro PIPE_SLICE_PERF_EN adds a saturating stall counter.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   up_data/up_valid/up_ready       producer side
//   down_data/down_valid/down_ready consumer side
//   stall_cnt (PIPE_SLICE_PERF_EN only) cycles with down_valid & !down_ready
module pipe_reg_slice
    import pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STAGES = 1,
    parameter int MODE   = MODE_SKID
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [DATA_W-1:0] down_data,
    output logic              down_valid,
    input  logic              down_ready
`ifdef PIPE_SLICE_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    generate
        if (STAGES < 1 || DATA_W < 1 || MODE > 1 || MODE < 0) begin : g_param_err
            $fatal(1, "pipe_reg_slice: illegal parameters");
        end
    endgenerate

    // Chain node i feeds stage i; node STAGES is the block output.
    logic [STAGES:0][DATA_W-1:0] ch_data;
    logic [STAGES:0]             ch_valid;
    logic [STAGES:0]             ch_ready;

    assign ch_data[0]       = up_data;
    assign ch_valid[0]      = up_valid;
    assign up_ready         = ch_ready[0];
    assign down_data        = ch_data[STAGES];
    assign down_valid       = ch_valid[STAGES];
    assign ch_ready[STAGES] = down_ready;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            pipe_reg_slice_stage #(
                .DATA_W (DATA_W),
                .MODE   (MODE)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .up_data    (ch_data[i]),
                .up_valid   (ch_valid[i]),
                .up_ready   (ch_ready[i]),
                .down_data  (ch_data[i+1]),
                .down_valid (ch_valid[i+1]),
                .down_ready (ch_ready[i+1])
            );
        end
    endgenerate

`ifdef PIPE_SLICE_PERF_EN
    // Observes the output handshake only; never feeds back into the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (down_valid && !down_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_reg_slice.sv
module tb_pipe_reg_slice;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ud, dd, h_ud, h_dd;
    logic       uv, ur, dv, dr, h_uv, h_ur, h_dv, h_dr;
`ifdef PIPE_SLICE_PERF_EN
    logic [15:0] stall_cnt, h_stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_reg_slice #(.DATA_W(8), .STAGES(2), .MODE(MODE_SKID)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_data(ud), .up_valid(uv), .up_ready(ur),
        .down_data(dd), .down_valid(dv), .down_ready(dr)
`ifdef PIPE_SLICE_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    pipe_reg_slice #(.DATA_W(8), .STAGES(1), .MODE(MODE_HALF)) dut_half (
        .clk(clk), .rst_n(rst_n),
        .up_data(h_ud), .up_valid(h_uv), .up_ready(h_ur),
        .down_data(h_dd), .down_valid(h_dv), .down_ready(h_dr)
`ifdef PIPE_SLICE_PERF_EN
        , .stall_cnt(h_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on input transfer, pop/compare on output transfer.
    // Inputs change at posedge+1, so negedge sees what the next edge transfers.
    logic [7:0] sb[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_dd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(dv), 32'd1);
                chk("hold_data", 32'(dd), 32'(prev_dd));
            end
            if (uv && ur) sb.push_back(ud);
            if (dv && dr) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow got %0h expected none", dd);
                end else begin
                    chk("sb_order", 32'(dd), 32'(sb.pop_front()));
                end
            end
            prev_hold = dv && !dr;
            prev_dd   = dd;
        end
    end

    typedef struct {
        logic       uv;
        logic [7:0] ud;
        logic       dr;
        logic       ur;
        logic       dv;
        logic [7:0] dd;
    } vec_t;

    vec_t tbl[12];

    task automatic drain();
        uv = 1'b0;
        dr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !dv) break;
            tick();
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_dv", 32'(dv), 32'd0);
    endtask

    initial begin
        int n;
        int acc_cnt;

        // Hand-computed two-stage skid trace: fill, skid, stall, refill, drain.
        tbl[0]  = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA1};
        tbl[4]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1};
        tbl[5]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA1};
        tbl[6]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA1};
        tbl[7]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA2};
        tbl[8]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA3};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5};

        rst_n = 1'b0;
        uv = 1'b0; ud = '0; dr = 1'b0;
        h_uv = 1'b0; h_ud = '0; h_dr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ur", 32'(ur), 32'd1);
        chk("rst_dv", 32'(dv), 32'd0);
        chk("rst_dd", 32'(dd), 32'd0);
        chk("rst_h_ur", 32'(h_ur), 32'd1);
        chk("rst_h_dv", 32'(h_dv), 32'd0);
`ifdef PIPE_SLICE_PERF_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Table-driven trace
        for (int i = 0; i < 12; i++) begin
            uv = tbl[i].uv; ud = tbl[i].ud; dr = tbl[i].dr;
            @(negedge clk);
            chk($sformatf("tbl%0d_ur", i), 32'(ur), 32'(tbl[i].ur));
            chk($sformatf("tbl%0d_dv", i), 32'(dv), 32'(tbl[i].dv));
            chk($sformatf("tbl%0d_dd", i), 32'(dd), 32'(tbl[i].dd));
            tick();
        end

        // Reset with 3 beats buffered: outputs clear in the same cycle
        dr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            uv = 1'b1; ud = 8'h50 + 8'(i);
            tick();
        end
        uv = 1'b0;
        chk("pre_rst_dv", 32'(dv), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_dv", 32'(dv), 32'd0);
        chk("midrst_dd", 32'(dd), 32'd0);
        chk("midrst_ur", 32'(ur), 32'd1);
        tick();
        rst_n = 1'b1;
        dr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_dv", 32'(dv), 32'd0);
            tick();
        end

        // Stream 0x01..0x10 back-to-back: 2-cycle latency, no gaps
        for (int k = 0; k < 20; k++) begin
            uv = (k < 16);
            ud = (k < 16) ? 8'(k + 1) : 8'h00;
            dr = 1'b1;
            @(negedge clk);
            chk("stream_ur", 32'(ur), 32'd1);
            chk("stream_dv", 32'(dv), 32'((k >= 2 && k < 18) ? 1 : 0));
            if (k >= 2 && k < 18) chk("stream_dd", 32'(dd), 32'(k - 1));
            tick();
        end
        drain();

        // Backpressure: 8 cycles blocked -> exactly 4 accepted
        n = 0;
        acc_cnt = 0;
        dr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            uv = 1'b1; ud = 8'h20 + 8'(n);
            @(negedge clk);
            if (ur) begin acc_cnt++; n++; end
            tick();
        end
        chk("bp_accepted", 32'(acc_cnt), 32'd4);
        chk("bp_ur_low", 32'(ur), 32'd0);
        dr = 1'b1;
        for (int k = 0; k < 40 && n < 8; k++) begin
            uv = 1'b1; ud = 8'h20 + 8'(n);
            @(negedge clk);
            if (ur) n++;
            tick();
        end
        chk("bp_sent", 32'(n), 32'd8);
        drain();

        // Random valid/ready
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            uv = 1'($urandom_range(0, 1));
            dr = ($urandom_range(0, 3) != 0);
            ud = 8'(n);
            @(negedge clk);
            if (uv && ur) n++;
            tick();
        end
        drain();

        // Half-throughput slice: ready toggles, one beat every 2 cycles
        h_dr = 1'b1;
        h_uv = 1'b1;
        for (int k = 0; k < 8; k++) begin
            h_ud = 8'h70 + 8'(k);
            @(negedge clk);
            chk("half_ur", 32'(h_ur), 32'((k % 2 == 0) ? 1 : 0));
            chk("half_dv", 32'(h_dv), 32'((k % 2 == 1) ? 1 : 0));
            if (k % 2 == 1) chk("half_dd", 32'(h_dd), 32'(8'h70 + 8'(k - 1)));
            tick();
        end
        h_uv = 1'b0;

`ifdef PIPE_SLICE_PERF_EN
        // Saturation: hold one beat under backpressure past 16'hFFFF cycles
        uv = 1'b1; ud = 8'hEE; dr = 1'b0;
        tick();
        uv = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
